// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the PC, reads the synchronous instruction memory,
// presents each instruction to the decoder and resolves jumps through a writable target LUT.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stall,
    input  logic               flag_ge,
    input  logic               flag_gt,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    input  logic               lut_wr_en,
    input  logic [3:0]         lut_addr,
    input  logic [PC_W-1:0]    lut_data
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_imem_addr;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic [PC_W-1:0]     r_lut [LUT_DEPTH];

    logic [4:0]          w_op;
    logic                w_halt;
    logic                w_take;
    logic [PC_W-1:0]     w_tgt;
    logic [PC_W-1:0]     w_pc_inc;
    logic [PC_W-1:0]     w_next_pc;

    assign w_op     = r_instr[8:4];
    assign w_halt   = (r_instr[8:3] == 6'b111111);
    assign w_tgt    = r_lut[r_instr[3:0]];
    assign w_pc_inc = r_pc + PC_ONE;

    always_comb begin
        w_take = 1'b0;
        case (w_op)
            5'b10010: w_take = 1'b1;
            5'b10000: w_take = flag_ge;
            5'b10001: w_take = flag_gt;
            default:  w_take = 1'b0;
        endcase
        w_next_pc = w_take ? w_tgt : w_pc_inc;
    end

    // A jump reading an entry in its write cycle sees the pre-write value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) r_lut[i] <= '0;
        end else if (lut_wr_en) begin
            r_lut[lut_addr] <= lut_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_imem_addr <= '0;
            r_instr     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_pc        <= '0;
                        r_imem_addr <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_instr <= imem_data;
                    r_valid <= 1'b1;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!stall) begin
                        r_valid <= 1'b0;
                        if (w_halt) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // address goes out with the state change so data is ready by FETCH's end
                            r_state     <= S_FETCH;
                            r_pc        <= w_next_pc;
                            r_imem_addr <= w_next_pc;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_addr   = r_imem_addr;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a program interpreter predicts the (pc, instr) stream
// seen on every valid cycle; a monitor compares it against the DUT.
module tb_fetch_unit;

    typedef struct packed {
        logic [9:0] pc;
        logic [8:0] ins;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start, stall, flag_ge, flag_gt, lut_wr_en;
    logic [3:0] lut_addr;
    logic [9:0] lut_data, imem_addr, pc;
    logic [8:0] imem_data, instr;
    logic       instr_valid, busy, done;

    logic       start_main = 1'b0, start_noise = 1'b0;
    logic       main_wr = 1'b0, drv_wr = 1'b0;
    logic [3:0] main_addr = '0, drv_addr = '0;
    logic [9:0] main_data = '0, drv_data = '0;

    logic [8:0] mem [1024];
    int         lut_model [16];
    int         stall_tab [64];
    bit         fge_tab [64];
    bit         fgt_tab [64];
    int         wr_step, wr_idx, wr_val;
    int         drv_idx = 0, drv_rep = 0;
    exp_t       exp_q [$];
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    assign start     = start_main | start_noise;
    assign lut_wr_en = main_wr | drv_wr;
    assign lut_addr  = drv_wr ? drv_addr : main_addr;
    assign lut_data  = drv_wr ? drv_data : main_data;
    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
        .flag_ge(flag_ge), .flag_gt(flag_gt), .imem_addr(imem_addr),
        .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .busy(busy), .done(done), .lut_wr_en(lut_wr_en),
        .lut_addr(lut_addr), .lut_data(lut_data)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Driver: stalls, flags and same-cycle LUT writes keyed to the instruction index.
    initial begin
        stall = 1'b0; flag_ge = 1'b0; flag_gt = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (start_main) begin drv_idx = 0; drv_rep = 0; end
            drv_wr = 1'b0;
            start_noise = busy && ($urandom_range(0, 7) == 0);
            if (instr_valid) begin
                flag_ge = fge_tab[drv_idx & 63];
                flag_gt = fgt_tab[drv_idx & 63];
                if (drv_rep < stall_tab[drv_idx & 63]) begin
                    stall = 1'b1;
                    drv_rep++;
                end else begin
                    stall = 1'b0;
                    if (drv_idx == wr_step) begin
                        drv_wr = 1'b1; drv_addr = wr_idx[3:0]; drv_data = wr_val[9:0];
                    end
                    drv_rep = 0;
                    drv_idx++;
                end
            end else begin
                stall   = 1'($urandom_range(0, 1));
                flag_ge = 1'($urandom_range(0, 1));
                flag_gt = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && instr_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_valid: valid at pc %0h, nothing expected", pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pc", 32'(pc), 32'(e.pc));
                    check("instr", 32'(instr), 32'(e.ins));
                end
            end
        end
    end

    // Reference interpreter: executes the program image step by step.
    task automatic build_model(input int nmax, output bit halted, output int hpc, output int steps);
        int p = 0;
        int tgt, nx;
        logic [8:0] w;
        halted = 0; hpc = 0; steps = nmax;
        for (int i = 0; i < nmax; i++) begin
            w = mem[p];
            for (int r = 0; r <= stall_tab[i]; r++) exp_q.push_back('{pc: p[9:0], ins: w});
            tgt = lut_model[w[3:0]];
            nx  = (p + 1) % 1024;
            if (w[8:4] == 5'b10010) nx = tgt;
            else if (w[8:4] == 5'b10000 && fge_tab[i]) nx = tgt;
            else if (w[8:4] == 5'b10001 && fgt_tab[i]) nx = tgt;
            if (i == wr_step) lut_model[wr_idx] = wr_val;
            if (w[8:3] == 6'h3F) begin halted = 1; hpc = p; steps = i + 1; break; end
            p = nx;
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_valid"}, 32'(instr_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pc"}, 32'(pc), 0);
        check({tag, "_addr"}, 32'(imem_addr), 0);
        check({tag, "_instr"}, 32'(instr), 0);
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 64; i++) begin stall_tab[i] = 0; fge_tab[i] = 0; fgt_tab[i] = 0; end
        wr_step = -1; wr_idx = 0; wr_val = 0;
        for (int a = 0; a < 1024; a++) mem[a] = 9'h040;
    endtask

    task automatic load_lut();
        for (int e = 0; e < 16; e++) begin
            @(negedge clk); #2;
            main_wr = 1'b1; main_addr = e[3:0]; main_data = lut_model[e][9:0];
        end
        @(negedge clk); #2;
        main_wr = 1'b0;
    endtask

    task automatic run(input int nmax, input bit timing);
        bit halted;
        int hpc, steps;
        build_model(nmax, halted, hpc, steps);
        @(negedge clk); #2; start_main = 1'b1;
        @(negedge clk); #2; start_main = 1'b0;
        check("done_low_after_start", 32'(done), 0);
        check("busy_after_start", 32'(busy), 1);
        if (timing) begin
            for (int k = 1; k <= 10; k++) begin
                if (k > 1) begin @(negedge clk); #2; end
                check("t_valid", 32'(instr_valid), 32'((k % 2 == 0) && k >= 2 && k <= 8));
                if (k % 2 == 0 && k <= 8) check("t_pc", 32'(pc), 32'((k - 2) / 2));
                if (k % 2 == 1 && k <= 7) check("t_addr", 32'(imem_addr), 32'((k - 1) / 2));
                check("t_done", 32'(done), 32'(k >= 9));
            end
        end
        if (halted) begin
            for (int c = 0; c < 2000; c++) begin
                if (done) break;
                @(negedge clk); #2;
            end
            check("done_seen", 32'(done), 1);
            check("halt_pc", 32'(pc), 32'(hpc));
            check("halt_instr", 32'(instr), 32'h1FF);
            check("done_not_valid", 32'(instr_valid), 0);
            check("queue_drained", 32'(exp_q.size()), 0);
        end else begin
            for (int c = 0; c < 2000; c++) begin
                if (drv_idx >= steps) break;
                @(negedge clk); #2;
            end
            check("steps_reached", 32'(drv_idx), 32'(steps));
            check("valid_at_abort", 32'(instr_valid), 1);
            reset_n = 1'b0;
            #1;
            chk_zero("abort");
            check("queue_drained", 32'(exp_q.size()), 0);
            exp_q.delete();
            @(negedge clk); #2; reset_n = 1'b1;
            for (int e = 0; e < 16; e++) lut_model[e] = 0;
        end
    endtask

    task automatic fill_rand();
        int r;
        logic [8:0] w;
        for (int a = 0; a < 1024; a++) begin
            r = $urandom_range(0, 99);
            if (r < 8) w = 9'h1FF;
            else if (r < 30) w = {3'b100, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            else begin
                w = 9'($urandom_range(0, 511));
                while (w[8:3] == 6'h3F || w[8:4] == 5'b10000 || w[8:4] == 5'b10001 || w[8:4] == 5'b10010)
                    w = 9'($urandom_range(0, 511));
            end
            mem[a] = w;
        end
    endtask

    initial begin
        clear_cfg();
        for (int e = 0; e < 16; e++) lut_model[e] = 0;
        #1; chk_zero("reset");
        @(negedge clk); #2; reset_n = 1'b1;

        // Sequential program with cycle-exact timing
        for (int e = 0; e < 16; e++) lut_model[e] = $urandom_range(0, 1023);
        load_lut();
        mem[0] = 9'h040; mem[1] = 9'h048; mem[2] = 9'h050; mem[3] = 9'h1FF;
        run(10, 1);

        // Unconditional jump (restart from DONE)
        clear_cfg();
        lut_model[5] = 100; load_lut();
        mem[0] = 9'h125; mem[100] = 9'h1FF;
        run(10, 0);

        // jge / jg with both flag values
        for (int j = 0; j < 4; j++) begin
            clear_cfg();
            lut_model[2] = 40; load_lut();
            mem[0] = (j < 2) ? 9'h102 : 9'h112; mem[1] = 9'h1FF; mem[40] = 9'h1FF;
            fge_tab[0] = (j == 1); fgt_tab[0] = (j == 3);
            run(10, 0);
        end

        // Stall for 3 cycles at pc=2
        clear_cfg();
        mem[4] = 9'h1FF; stall_tab[2] = 3;
        run(10, 0);

        // Wrap 1023 -> 0, then fall through to a halt at 1
        clear_cfg();
        lut_model[1] = 1023; load_lut();
        mem[0] = 9'h101; mem[1] = 9'h1FF;
        fge_tab[0] = 1; fge_tab[2] = 0;
        run(10, 0);

        // LUT write in the same cycle as the jump that reads it
        clear_cfg();
        lut_model[5] = 100; load_lut();
        mem[0] = 9'h125; mem[100] = 9'h125; mem[200] = 9'h1FF;
        stall_tab[0] = 2; wr_step = 0; wr_idx = 5; wr_val = 200;
        run(10, 0);

        // Mid-program reset, then LUT must read back as cleared
        clear_cfg();
        lut_model[7] = 300; load_lut();
        mem[0] = 9'h127;
        run(2, 0);
        run(3, 0);

        // Randomized programs
        for (int it = 0; it < 24; it++) begin
            clear_cfg();
            for (int e = 0; e < 16; e++) lut_model[e] = $urandom_range(0, 1023);
            load_lut();
            fill_rand();
            for (int i = 0; i < 64; i++) begin
                stall_tab[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                fge_tab[i] = 1'($urandom_range(0, 1));
                fgt_tab[i] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) begin
                wr_step = $urandom_range(0, 5); wr_idx = $urandom_range(0, 15); wr_val = $urandom_range(0, 1023);
            end
            run(25, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
